hd_rr_arbiter: RTL

- N-input, one-output round-robin arbiter for valid/ready handshake channels.
- Shares one downstream consumer between N requesters, one beat per grant.
- The output is a single registered slot, so the output is registered and full throughput is kept.
- Sits in front of HD stages wherever several producers feed one datapath.

---
 rtl/hd_rr_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/hd_rr_arbiter.sv
// rtl/hd_rr_arbiter.sv - N-input round-robin valid/ready arbiter with one registered output slot
// Optional packet lock: define HD_ARB_LOCK_EN to add the per-channel last input.
module hd_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int ID_WIDTH   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            valid,
  input  logic [N*DATA_WIDTH-1:0] data_src,
`ifdef HD_ARB_LOCK_EN
  input  logic [N-1:0]            last,
`endif
  output logic [N-1:0]            ready_output,
  output logic [DATA_WIDTH-1:0]   data_dest,
  output logic                    valid_output,
  input  logic                    ready,
  output logic [ID_WIDTH-1:0]     grant_id
);

  // Channel granted most recently; the search starts just after it.
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] sel;
  logic                found;
  logic                slot_free;
  logic                accept;

`ifdef HD_ARB_LOCK_EN
  logic                locked;
  logic [ID_WIDTH-1:0] lock_id;
`endif

  // Pick the first valid channel after ptr (or the locked channel while a packet is open).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int cand;
      cand = (int'(ptr) + off) % N;
      if (!found && valid[cand]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(cand);
      end
    end
`ifdef HD_ARB_LOCK_EN
    if (locked) begin
      sel   = lock_id;
      found = valid[lock_id];
    end
`endif
  end

  // Slot can take a beat when empty or when the held beat drains this cycle; nothing is accepted in reset.
  always_comb begin
    slot_free    = !valid_output || ready;
    accept       = rst && slot_free && found;
    ready_output = '0;
    if (accept) begin
      ready_output[sel] = 1'b1;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_output <= 1'b0;
      data_dest    <= '0;
      grant_id     <= '0;
      ptr          <= ID_WIDTH'(N - 1);
    end else if (accept) begin
      valid_output <= 1'b1;
      data_dest    <= data_src[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      grant_id     <= sel;
      ptr          <= sel;
    end else if (ready) begin
      valid_output <= 1'b0;
    end
  end

`ifdef HD_ARB_LOCK_EN
  // Hold the grant on a channel until it delivers a beat marked last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      locked  <= !last[sel];
      lock_id <= sel;
    end
  end
`endif

endmodule
